// File: rtl/instr_fetch_seq_if.sv
// Fetch-to-ROM / fetch-to-execute signal bundle for instr_fetch_seq.
// Carries oStallCount only when FETCH_STALL_CNT_EN is defined.
interface instr_fetch_seq_if #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 32
);
    logic                iEnable;
    logic [ADDR_W-1:0]   oAddress;
    logic [INSTR_W-1:0]  iInstruction;
    logic [INSTR_W-1:0]  oInstruction;
    logic                oValid;
    logic                iReady;
    logic                iRedirect;
    logic [ADDR_W-1:0]   iRedirectAddr;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0]         oStallCount;

    modport master (
        input  iEnable, iInstruction, iReady, iRedirect, iRedirectAddr,
        output oAddress, oInstruction, oValid, oStallCount
    );
    modport slave (
        output iEnable, iInstruction, iReady, iRedirect, iRedirectAddr,
        input  oAddress, oInstruction, oValid, oStallCount
    );
`else
    modport master (
        input  iEnable, iInstruction, iReady, iRedirect, iRedirectAddr,
        output oAddress, oInstruction, oValid
    );
    modport slave (
        output iEnable, iInstruction, iReady, iRedirect, iRedirectAddr,
        input  oAddress, oInstruction, oValid
    );
`endif
endinterface

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: owns the PC, resolves JMP in fetch, runs NOP delays locally.
// Optional FETCH_STALL_CNT_EN adds a saturating back-pressure cycle counter (oStallCount).
module instr_fetch_seq #(
    parameter int         ADDR_W  = 10,
    parameter int         INSTR_W = 32,
    parameter int         DELAY_W = 24,
    parameter logic [7:0] OPC_NOP = 8'h00,
    parameter logic [7:0] OPC_JMP = 8'h01
) (
    input  logic              Clock,
    input  logic              Reset,
    instr_fetch_seq_if.master bus
);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [DELAY_W-1:0]   cnt_q, cnt_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 valid_q, valid_d;

    logic [7:0]           opcode;
    logic [DELAY_W-1:0]   delay;
    logic [ADDR_W-1:0]    jmp_target;
    logic                 slot_free;

    assign opcode    = bus.iInstruction[INSTR_W-1 -: 8];
    assign delay     = bus.iInstruction[DELAY_W-1:0];
    assign slot_free = !valid_q || bus.iReady;

    // Zero-extend or truncate the 8-bit jump field to the PC width.
    always_comb begin
        jmp_target = '0;
        for (int i = 0; i < ADDR_W && i < 8; i++) begin
            jmp_target[i] = bus.iInstruction[16+i];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        valid_d = valid_q;

        if (bus.iRedirect) begin
            pc_d    = bus.iRedirectAddr;
            valid_d = 1'b0;
            state_d = S_RUN;
            cnt_d   = '0;
        end else begin
            if (valid_q && bus.iReady) begin
                valid_d = 1'b0;
            end
            if (bus.iEnable) begin
                case (state_q)
                    S_RUN: begin
                        if (slot_free) begin
                            if (opcode == OPC_JMP) begin
                                pc_d = jmp_target;
                            end else if (opcode == OPC_NOP && delay != '0) begin
                                pc_d    = pc_q + ADDR_W'(1);
                                cnt_d   = delay;
                                state_d = S_WAIT;
                            end else begin
                                instr_d = bus.iInstruction;
                                valid_d = 1'b1;
                                pc_d    = pc_q + ADDR_W'(1);
                            end
                        end
                    end
                    S_WAIT: begin
                        // Counter holds remaining wait cycles; the last one returns to RUN.
                        if (cnt_q <= DELAY_W'(1)) begin
                            cnt_d   = '0;
                            state_d = S_RUN;
                        end else begin
                            cnt_d = cnt_q - DELAY_W'(1);
                        end
                    end
                    default: state_d = S_RUN;
                endcase
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign bus.oAddress     = pc_q;
    assign bus.oInstruction = instr_q;
    assign bus.oValid       = valid_q;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (bus.iRedirect) begin
            stall_d = '0;
        end else if (valid_q && !bus.iReady && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.oStallCount = stall_q;
`endif

endmodule
